cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among the functional units of the out-of-order core: ALU, load/store, branch and others. Each unit presents a completed result (16-bit data plus 3-bit ROB tag) with a valid/ready handshake. The arbiter grants at most one requester per cycle and drives a registered `CDB` struct broadcast to the reservation stations, register file and ROB. A synchronous flush squashes in-flight broadcasts on branch mispredict.

## Interface
- `NUM_REQ`, 4: number of requesting functional units; legal range 2..8.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous squash; takes effect at the next rising edge.
- `req_valid` input `[NUM_REQ]`: requester i has a result to broadcast.
- `req_data` input `[NUM_REQ][16]`: `lc3b_word` result per requester.
- `req_tag` input `[NUM_REQ][3]`: `lc3b_rob_addr` destination tag per requester.
- `req_ready` output `[NUM_REQ]`: combinational grant; one-hot or zero.
- `cdb_out` output `CDB` (20 bits): registered broadcast `{valid, data, tag}`.
- `grant_id` output 3: index of the requester whose result is on `cdb_out`; meaningful only when `cdb_out.valid` is high.

## Operation
- Transfer rule: requester i transfers in cycle t when `req_valid[i] && req_ready[i]` at the rising edge ending cycle t.
- Requesters hold `req_valid`, `req_data` and `req_tag` stable until accepted.
- Grant selection:
  - Scan `req_valid` starting at pointer `rr_ptr` (`$clog2(NUM_REQ)` bits), wrapping modulo `NUM_REQ`.
  - The first valid index found gets `req_ready` high.
  - All other `req_ready` bits are low.
- Pointer update: on a transfer from index i, `rr_ptr` becomes `(i+1) mod NUM_REQ`. With no transfer, `rr_ptr` holds.
- Broadcast on transfer:
  - Next cycle, `cdb_out` = `{1, req_data[i], req_tag[i]}` and `grant_id` = i.
  - With no transfer, `cdb_out.valid` = 0, while `cdb_out.data` and `cdb_out.tag` hold their last values.
- Flush:
  - While `flush` = 1, all `req_ready` bits are 0, so no transfer occurs.
  - Next cycle, `cdb_out.valid` = 0 and `rr_ptr` = 0.
  - A broadcast already on `cdb_out` during the flush cycle completes unchanged; consumers qualify it with the flush themselves.
- Fairness: any requester that stays continuously valid is granted within `NUM_REQ` cycles.
- The arbiter has no internal buffering; back-pressure is provided entirely through `req_ready`.

## Timing
- Reset values:
  - `cdb_out` = all zeros: valid 0, data 16'h0000, tag 3'b000.
  - `grant_id` = 0.
  - `rr_ptr` = 0.
  - `req_ready` = 0 while `reset` is asserted.
- After reset deasserts, the first grant can occur in the first clock cycle.
- Latency: accept edge to `cdb_out.valid` high is exactly 1 cycle. Each broadcast lasts exactly 1 cycle.
- Throughput: 1 broadcast per cycle; sustained back-to-back grants are allowed.
- `req_ready` is combinational from `req_valid`, `rr_ptr` and `flush`. It must not depend combinationally on `cdb_out`.
- `reset` asserted mid-broadcast clears `cdb_out.valid` immediately (asynchronous). The pending request is not lost; the requester retries.
- `flush` and `reset` asserted together: reset wins.
- A single valid requester is granted every cycle regardless of `rr_ptr`.

## Structure
- Package `lc3b_types` gains:
  - `CDB_MAX_REQ` = 8.
  - `cdb_req_t`, a packed struct `{logic valid; lc3b_word data; lc3b_rob_addr tag;}` for requester-side bundling.
- The existing `CDB` struct is reused unchanged for `cdb_out`.
- Sub-module `rr_pick`: combinational round-robin priority select.
  - Inputs: `req` vector and `ptr`.
  - Outputs: one-hot `gnt` and encoded `idx`.
  - Instantiated once.
- `cdb_arbiter` holds `rr_ptr` and the output register.

## Test plan
- Reset release with `req_valid`=4'b0000 → `cdb_out`=20'h0 and `req_ready`=4'b0000 for 3 cycles.
- Only req 2 valid, data 16'hBEEF, tag 3'd5 → `req_ready`=4'b0100 that cycle; next cycle `cdb_out`={1,16'hBEEF,3'd5} and `grant_id`=2.
- All 4 valid continuously from reset → grant order 0,1,2,3,0; `cdb_out.valid` high every cycle from cycle 1.
- Req 1 and req 3 valid with `rr_ptr`=2 → req 3 granted first, then req 1; pointer ends at 2.
- `flush` asserted while req 0 valid → `req_ready`=0 that cycle; next cycle `cdb_out.valid`=0 and `rr_ptr`=0; req 0 is granted the cycle after flush drops.
- Async `reset` pulse mid-cycle while `cdb_out.valid`=1 → `cdb_out.valid` drops before the next edge; the held request is granted after release.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared LC-3b core types used by the CDB arbiter and its consumers.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_rob_addr;

  // Common data bus broadcast seen by reservation stations, register file and ROB.
  typedef struct packed {
    logic         valid;
    lc3b_word     data;
    lc3b_rob_addr tag;
  } CDB;

  // Upper bound on the number of functional units sharing the CDB.
  localparam int unsigned CDB_MAX_REQ = 8;

  // Requester-side bundle of one completed result.
  typedef struct packed {
    logic         valid;
    lc3b_word     data;
    lc3b_rob_addr tag;
  } cdb_req_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin priority select: first set bit of req at or after ptr.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic w_found;

  // Scan from ptr upward, wrapping modulo N; the first valid index wins.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      logic [PW-1:0] w_j;
      w_j = PW'((32'(ptr) + k) % N);
      if (!w_found && req[w_j]) begin
        w_found  = 1'b1;
        gnt[w_j] = 1'b1;
        idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving the registered common data bus broadcast.
module cdb_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic         [NUM_REQ-1:0] req_valid,
  input  lc3b_word     [NUM_REQ-1:0] req_data,
  input  lc3b_rob_addr [NUM_REQ-1:0] req_tag,
  output logic         [NUM_REQ-1:0] req_ready,
  output CDB                         cdb_out,
  output logic         [2:0]         grant_id
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      r_ptr;
  CDB                 r_cdb;
  logic [2:0]         r_gid;

  logic [NUM_REQ-1:0] w_gnt;
  logic [PW-1:0]      w_idx;
  logic               w_xfer;
  logic [PW-1:0]      w_ptr_nxt;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_idx)
  );

  // Grant is suppressed during flush and while reset is held, so nothing transfers.
  always_comb begin
    req_ready = w_gnt & {NUM_REQ{~(flush | reset)}};
    w_xfer    = |req_ready;
    if (w_idx == PW'(NUM_REQ - 1)) w_ptr_nxt = '0;
    else                           w_ptr_nxt = PW'(w_idx + 1'b1);
  end

  // Pointer and broadcast register; data/tag hold when no transfer occurs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
      r_cdb <= '0;
      r_gid <= '0;
    end else if (flush) begin
      r_ptr       <= '0;
      r_cdb.valid <= 1'b0;
    end else if (w_xfer) begin
      r_ptr       <= w_ptr_nxt;
      r_cdb.valid <= 1'b1;
      r_cdb.data  <= req_data[w_idx];
      r_cdb.tag   <= req_tag[w_idx];
      r_gid       <= 3'(w_idx);
    end else begin
      r_cdb.valid <= 1'b0;
    end
  end

  assign cdb_out  = r_cdb;
  assign grant_id = r_gid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed table, corner sequences, random vs model.
module tb_cdb_arbiter;
  import lc3b_types::*;

  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 flush;
  logic [N-1:0]         req_valid;
  lc3b_word     [N-1:0] req_data;
  lc3b_rob_addr [N-1:0] req_tag;
  logic [N-1:0]         req_ready;
  CDB                   cdb_out;
  logic [2:0]           grant_id;

  cdb_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_tag   (req_tag),
    .req_ready (req_ready),
    .cdb_out   (cdb_out),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: pointer and the broadcast the bus should show.
  int m_ptr;
  CDB m_cdb;
  int m_gid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Winner = valid requester with the smallest forward distance from the pointer.
  function automatic int pick(input logic [N-1:0] v, input int ptr, input logic fl);
    int best = -1;
    int bd   = N;
    if (fl) return -1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        int d;
        d = (i - ptr + N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_cdb = '0;
    m_gid = 0;
  endtask

  // One cycle: check ready before the edge, advance the model, check the bus after it.
  task automatic step(input string nm, output int g);
    #2;
    g = pick(req_valid, m_ptr, flush);
    chk({nm, ".ready"}, 32'(req_ready), 32'(onehot(g)));
    @(posedge clk);
    if (flush) begin
      m_cdb.valid = 1'b0;
      m_ptr       = 0;
      g           = -1;
    end else if (g >= 0) begin
      m_cdb = {1'b1, req_data[g], req_tag[g]};
      m_gid = g;
      m_ptr = (g + 1) % N;
    end else begin
      m_cdb.valid = 1'b0;
    end
    #1;
    chk({nm, ".cdb"}, 32'(cdb_out), 32'(m_cdb));
    if (m_cdb.valid) chk({nm, ".gid"}, 32'(grant_id), 32'(m_gid));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    #1;
    chk("rst.cdb", 32'(cdb_out), 32'h0);
    chk("rst.ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic         flush;
    logic [N-1:0] exp_ready;
    logic         exp_v;
    logic [2:0]   exp_gid;
  } vec_t;

  vec_t tbl[11];
  int   g;

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      req_data[i] = 16'(16'h1111 * (i + 1));
      req_tag[i]  = 3'(i);
    end
    #1;
    chk("por.ready", 32'(req_ready), 32'h0);
    chk("por.cdb", 32'(cdb_out), 32'h0);
    #11 reset = 1'b0;
    model_reset();

    // Idle after reset release: bus and grants stay quiet.
    for (int c = 0; c < 3; c++) begin
      #2 chk("idle.ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1 chk("idle.cdb", 32'(cdb_out), 32'h0);
    end

    // Directed sequence starting at pointer 0.
    tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0};
    tbl[1]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 3'd2};
    tbl[2]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 3'd3};
    tbl[3]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 3'd0};
    tbl[4]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 3'd1};
    tbl[5]  = '{4'b1010, 1'b0, 4'b1000, 1'b1, 3'd3};
    tbl[6]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 3'd1};
    tbl[7]  = '{4'b1010, 1'b1, 4'b0000, 1'b0, 3'd0};
    tbl[8]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 3'd1};
    tbl[9]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 3'd0};
    tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0};
    for (int t = 0; t < 11; t++) begin
      req_valid = tbl[t].valid;
      flush     = tbl[t].flush;
      #2 chk($sformatf("tbl%0d.ready", t), 32'(req_ready), 32'(tbl[t].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.valid", t), 32'(cdb_out.valid), 32'(tbl[t].exp_v));
      if (tbl[t].exp_v) begin
        chk($sformatf("tbl%0d.gid", t), 32'(grant_id), 32'(tbl[t].exp_gid));
        chk($sformatf("tbl%0d.data", t), 32'(cdb_out.data), 32'(req_data[tbl[t].exp_gid]));
      end
    end
    flush = 1'b0;

    // Single requester with a distinctive payload.
    do_reset();
    req_valid   = 4'b0100;
    req_data[2] = 16'hBEEF;
    req_tag[2]  = 3'd5;
    step("beef", g);
    chk("beef.bus", 32'(cdb_out), 32'({1'b1, 16'hBEEF, 3'd5}));
    chk("beef.gid", 32'(grant_id), 32'd2);
    req_valid = '0;
    step("beef.after", g);

    // All requesters valid continuously: strict rotation from 0.
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step("rot", g);
      chk("rot.order", 32'(grant_id), 32'(k % N));
      chk("rot.valid", 32'(cdb_out.valid), 32'd1);
    end

    // Flush resets the pointer: after it, req 0 beats req 2.
    do_reset();
    req_valid = 4'b0010;
    step("fl.pre", g);
    req_valid = 4'b0101;
    flush     = 1'b1;
    step("fl.flush", g);
    chk("fl.valid", 32'(cdb_out.valid), 32'd0);
    flush = 1'b0;
    step("fl.post", g);
    chk("fl.gid", 32'(grant_id), 32'd0);

    // Asynchronous reset in the middle of a broadcast; request retried afterwards.
    do_reset();
    req_valid = 4'b0001;
    step("ar.pre", g);
    #1 reset = 1'b1;
    #1;
    chk("ar.valid", 32'(cdb_out.valid), 32'd0);
    chk("ar.ready", 32'(req_ready), 32'h0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    step("ar.retry", g);
    chk("ar.gid", 32'(grant_id), 32'd0);
    chk("ar.v", 32'(cdb_out.valid), 32'd1);

    // Random traffic: requests hold until accepted, occasional flush.
    do_reset();
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 99) < 55) begin
          req_valid[i] = 1'b1;
          req_data[i]  = 16'($urandom);
          req_tag[i]   = 3'($urandom);
        end
      end
      flush = ($urandom_range(0, 15) == 0);
      step("rnd", g);
      if (g >= 0) req_valid[g] = 1'b0;
    end
    flush     = 1'b0;
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
